// File: rtl/shift_accumulate_unit.sv
// -----------------------------------------------------------------------------
// shift_accumulate_unit
//
// Sequential accumulator that sits directly after the nibble shift stage. Each
// accepted beat carries one shifted partial product (IX_SL). The beat's term is
// added to the running sum, or subtracted when SUB=1. After NUM_NIBBLES beats
// the completed product is registered into ACC_OUT. It is held there with
// out_valid until the PE output register takes it.
//
// Optional build macro: ACC_SATURATE_EN
//   undefined : accumulation wraps modulo 2^ACC_WIDTH
//   defined   : each add clamps to the signed ACC_WIDTH range on overflow
//   Ports and timing are identical in both builds.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   IX_SL      in   [2*WIDTH-1:0] unsigned shifted partial product
//   SUB        in   1 = subtract this beat's term, 0 = add it
//   in_valid   in   IX_SL/SUB valid
//   in_ready   out  beat taken when in_valid & in_ready
//   clear      in   synchronous flush of the in-progress product
//   ACC_OUT    out  [ACC_WIDTH-1:0] completed product, two's complement
//   out_valid  out  ACC_OUT valid
//   out_ready  in   downstream takes ACC_OUT when out_valid & out_ready
//   beat_cnt   out  [LOG2_WIDTH-1:0] beats held for the current product
// -----------------------------------------------------------------------------
module shift_accumulate_unit #(
  parameter int LOG2_WIDTH        = 4,
  parameter int WIDTH             = 2**LOG2_WIDTH,
  parameter int LOG2_NIBBLE_WIDTH = 2,
  parameter int NIBBLE_WIDTH      = 2**LOG2_NIBBLE_WIDTH,
  parameter int NUM_NIBBLES       = (WIDTH/NIBBLE_WIDTH < 1) ? 1 : WIDTH/NIBBLE_WIDTH,
  parameter int ACC_WIDTH         = 2*WIDTH+2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2*WIDTH-1:0]    IX_SL,
  input  logic                  SUB,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  clear,
  output logic [ACC_WIDTH-1:0]  ACC_OUT,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LOG2_WIDTH-1:0] beat_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } state_e;

  // beat_cnt value at which the next accepted beat finishes the product.
  localparam logic [LOG2_WIDTH-1:0] LAST_CNT = LOG2_WIDTH'(NUM_NIBBLES-1);

  state_e                  state_q, state_d;
  logic [ACC_WIDTH-1:0]    acc_q, acc_d;
  logic [ACC_WIDTH-1:0]    acc_out_q, acc_out_d;
  logic [LOG2_WIDTH-1:0]   cnt_q, cnt_d;

  logic [ACC_WIDTH-1:0]    ix_ext;
  logic [ACC_WIDTH-1:0]    term;
  logic [ACC_WIDTH-1:0]    sum;
  logic                    hold;
  logic                    pop;
  logic                    accept;
  logic                    last;

  // The upper IX_SL bits are dropped when ACC_WIDTH is narrower than the operand.
  logic                    unused_ix;
  assign unused_ix = ^IX_SL;

  // ---------------------------------------------------------------------------
  // Term: the zero-extended operand, negated for a subtract beat.
  // ---------------------------------------------------------------------------
  always_comb begin
    ix_ext = ACC_WIDTH'(IX_SL);
    term   = SUB ? (-ix_ext) : ix_ext;
  end

  // ---------------------------------------------------------------------------
  // Adder. acc_q is always zero in IDLE and HOLD. This means a beat accepted
  // in the same cycle as an output pop starts a fresh product from the term
  // alone.
  // ---------------------------------------------------------------------------
`ifdef ACC_SATURATE_EN
  localparam logic [ACC_WIDTH-1:0] SAT_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] SAT_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  logic [ACC_WIDTH:0] wide_sum;

  always_comb begin
    // Sign-extend both operands one bit. The top two bits disagree exactly
    // when the signed ACC_WIDTH result has overflowed. The top bit is the
    // true sign, so it selects the clamp direction.
    wide_sum = {acc_q[ACC_WIDTH-1], acc_q} + {term[ACC_WIDTH-1], term};
    if (wide_sum[ACC_WIDTH] != wide_sum[ACC_WIDTH-1]) begin
      sum = wide_sum[ACC_WIDTH] ? SAT_MIN : SAT_MAX;
    end else begin
      sum = wide_sum[ACC_WIDTH-1:0];
    end
  end
`else
  assign sum = acc_q + term;
`endif

  // ---------------------------------------------------------------------------
  // Handshake and next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    acc_out_d = acc_out_q;
    cnt_d     = cnt_q;

    hold     = (state_q == S_HOLD);
    pop      = hold & out_ready;
    // in_ready depends only on state, out_ready and clear, never on in_valid.
    // While a result is held, a slot frees up only in the cycle that it is
    // popped.
    in_ready = ~clear & (~hold | out_ready);
    accept   = in_valid & in_ready;
    last     = (cnt_q == LAST_CNT);

    if (pop) begin
      state_d = S_IDLE;
    end

    if (clear) begin
      // Flush the partial product only. A held result still drains through
      // pop.
      acc_d = '0;
      cnt_d = '0;
      if (state_q == S_ACCUM) begin
        state_d = S_IDLE;
      end
    end else if (accept) begin
      if (last) begin
        acc_out_d = sum;
        acc_d     = '0;
        cnt_d     = '0;
        state_d   = S_HOLD;
      end else begin
        acc_d     = sum;
        cnt_d     = cnt_q + 1'b1;
        state_d   = S_ACCUM;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      acc_out_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      acc_out_q <= acc_out_d;
      cnt_q     <= cnt_d;
    end
  end

  assign ACC_OUT   = acc_out_q;
  assign out_valid = (state_q == S_HOLD);
  assign beat_cnt  = cnt_q;

endmodule

// File: tb/tb_shift_accumulate_unit.sv
// -----------------------------------------------------------------------------
// Testbench for shift_accumulate_unit.
//
// The stimulus tasks drive beats. The reference model keeps the product as a
// plain signed integer. At the end of each product, the expected result is
// queued. A monitor pops the queue and compares it with ACC_OUT whenever the
// DUT hands over a result. A second instance, with ACC_WIDTH=8, covers the
// narrow-accumulator overflow case.
// -----------------------------------------------------------------------------
module tb_shift_accumulate_unit;

  localparam int AW  = 34;
  localparam int NNB = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;

  logic [31:0]   IX_SL    = '0;
  logic          SUB      = 1'b0;
  logic          in_valid = 1'b0;
  logic          clear    = 1'b0;
  logic          out_ready = 1'b1;
  logic          in_ready;
  logic          out_valid;
  logic [AW-1:0] ACC_OUT;
  logic [3:0]    beat_cnt;

  logic [31:0]   ix8     = '0;
  logic          sub8    = 1'b0;
  logic          iv8     = 1'b0;
  logic          clr8    = 1'b0;
  logic          ordy8   = 1'b1;
  logic          irdy8;
  logic          ov8;
  logic [7:0]    acc8;
  logic [3:0]    bc8;

  shift_accumulate_unit dut (
    .clk(clk), .rst(rst), .IX_SL(IX_SL), .SUB(SUB), .in_valid(in_valid),
    .in_ready(in_ready), .clear(clear), .ACC_OUT(ACC_OUT), .out_valid(out_valid),
    .out_ready(out_ready), .beat_cnt(beat_cnt)
  );

  shift_accumulate_unit #(.ACC_WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .IX_SL(ix8), .SUB(sub8), .in_valid(iv8),
    .in_ready(irdy8), .clear(clr8), .ACC_OUT(acc8), .out_valid(ov8),
    .out_ready(ordy8), .beat_cnt(bc8)
  );

  always #5 clk = ~clk;

  int            n_cmp = 0;
  int            n_err = 0;
  logic [AW-1:0] exp_q[$];
  longint        model_acc = 0;
  int            model_cnt = 0;
  bit            rnd = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Reference model for one beat: a signed add, clamped to the AW-bit signed
  // range when saturation is built in. Without saturation, the product is
  // reduced modulo 2^AW when it is queued.
  function automatic longint step(input longint acc, input logic [31:0] ix, input logic sub);
    longint t;
    longint r;
    t = sub ? -longint'({32'b0, ix}) : longint'({32'b0, ix});
    r = acc + t;
`ifdef ACC_SATURATE_EN
    if (r > ((longint'(1) <<< (AW-1)) - 1)) r = (longint'(1) <<< (AW-1)) - 1;
    if (r < -(longint'(1) <<< (AW-1)))      r = -(longint'(1) <<< (AW-1));
`endif
    return r;
  endfunction

  // Monitor: one comparison for every result handed over.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_output: got %h, expected no result", ACC_OUT);
      end else begin
        chk("scoreboard_acc_out", 64'(ACC_OUT), 64'(exp_q.pop_front()));
      end
    end
  end

  // Offer one beat and keep it offered until it is accepted. Then update the
  // model. This task is entered and left at posedge+1.
  task automatic send_beat(input logic [31:0] ix, input logic sub);
    int n;
    n = 0;
    IX_SL    = ix;
    SUB      = sub;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready) begin
      n++;
      if (n > 200) begin
        n_cmp++;
        n_err++;
        $display("FAIL accept_timeout: in_ready 0 for 200 cycles, expected 1");
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    chk("beat_cnt", 64'(beat_cnt), 64'(model_cnt));
    @(posedge clk); #1;
    in_valid  = 1'b0;
    model_acc = step(model_acc, ix, sub);
    model_cnt++;
    if (model_cnt == NNB) begin
      exp_q.push_back(model_acc[AW-1:0]);
      model_acc = 0;
      model_cnt = 0;
      chk("out_valid_latency", 64'(out_valid), 64'd1);
    end
  endtask

  initial begin
    logic [31:0] rix;
    logic        rsub;

    // Reset state
    #2;
    chk("rst_acc_out", 64'(ACC_OUT), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_beat_cnt", 64'(beat_cnt), 64'd0);
    #21 rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // Back-to-back add beats
    out_ready = 1'b1;
    send_beat(32'h0003, 1'b0);
    send_beat(32'h0030, 1'b0);
    send_beat(32'h0300, 1'b0);
    send_beat(32'h3000, 1'b0);
    chk("acc_out_3333", 64'(ACC_OUT), 64'h3333);
    @(posedge clk); #1;
    chk("out_valid_one_cycle", 64'(out_valid), 64'd0);

    // Mixed add/subtract beats
    send_beat(32'd10, 1'b0);
    send_beat(32'd3,  1'b1);
    send_beat(32'd0,  1'b0);
    send_beat(32'd0,  1'b0);
    chk("acc_out_7", 64'(ACC_OUT), 64'd7);
    send_beat(32'd0,  1'b0);
    send_beat(32'd5,  1'b1);
    send_beat(32'd0,  1'b0);
    send_beat(32'd0,  1'b0);
    chk("acc_out_neg5", 64'(ACC_OUT), 64'h3_FFFF_FFFB);
    @(posedge clk); #1;

    // Output stall, then a simultaneous pop and first beat
    out_ready = 1'b0;
    send_beat(32'd1, 1'b0);
    send_beat(32'd2, 1'b0);
    send_beat(32'd3, 1'b0);
    send_beat(32'd4, 1'b0);
    repeat (5) begin
      @(negedge clk);
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      chk("stall_out_valid", 64'(out_valid), 64'd1);
      chk("stall_acc_out", 64'(ACC_OUT), 64'd10);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send_beat(32'd5, 1'b0);
    chk("popbeat_beat_cnt", 64'(beat_cnt), 64'd1);
    chk("popbeat_out_valid", 64'(out_valid), 64'd0);
    send_beat(32'd0, 1'b0);
    send_beat(32'd0, 1'b0);
    send_beat(32'd0, 1'b0);

    // Asynchronous reset in the middle of a product
    send_beat(32'd1, 1'b0);
    send_beat(32'd1, 1'b0);
    #1 rst = 1'b1;
    #1;
    chk("arst_beat_cnt", 64'(beat_cnt), 64'd0);
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_acc_out", 64'(ACC_OUT), 64'd0);
    model_acc = 0;
    model_cnt = 0;
    #1 rst = 1'b0;
    @(posedge clk); #1;
    repeat (NNB) send_beat(32'd1, 1'b0);
    chk("arst_then_4", 64'(ACC_OUT), 64'd4);

    // Clear after three beats, with a beat offered in the same cycle
    repeat (3) send_beat(32'd7, 1'b0);
    clear    = 1'b1;
    IX_SL    = 32'd100;
    in_valid = 1'b1;
    @(negedge clk);
    chk("clear_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    chk("clear_beat_cnt", 64'(beat_cnt), 64'd0);
    model_acc = 0;
    model_cnt = 0;
    repeat (NNB) send_beat(32'd2, 1'b0);
    chk("clear_then_8", 64'(ACC_OUT), 64'd8);

    // Narrow accumulator: 0x7F + 1 overflows the signed 8-bit range
    iv8 = 1'b1;
    ix8 = 32'h7F;
    @(posedge clk); #1 ix8 = 32'h01;
    @(posedge clk); #1 ix8 = 32'h00;
    @(posedge clk); #1;
    @(posedge clk); #1 iv8 = 1'b0;
    chk("acc8_out_valid", 64'(ov8), 64'd1);
`ifdef ACC_SATURATE_EN
    chk("acc8_overflow", 64'(acc8), 64'h7F);
`else
    chk("acc8_overflow", 64'(acc8), 64'h80);
`endif

    // Randomized products with random input gaps and output back-pressure
    rnd = 1'b1;
    for (int p = 0; p < 40; p++) begin
      for (int b = 0; b < NNB; b++) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk); #1;
        end
        out_ready = ($urandom_range(0, 3) != 0);
        rix  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : 32'($urandom);
        rsub = 1'($urandom_range(0, 1));
        send_beat(rix, rsub);
      end
    end
    rnd = 1'b0;
    out_ready = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
    end
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
